// File: rtl/i2c_led_frame.sv
// Frame buffer behind the i2c slave core plus a WS2812-style serial driver.
// The first byte of a transfer sets the buffer pointer; STOP commits the shadow frame and starts a refresh.
module i2c_led_frame #(
  parameter int LED_CNT      = 3,
  parameter int CHANNELS     = 3,
  parameter int T0H          = 4,
  parameter int T1H          = 8,
  parameter int TBIT         = 12,
  parameter int RESET_CYCLES = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_start,
  input  logic       rx_stop,
  output logic       led_o,
  output logic       busy_o,
  output logic       pending_o
);

  // state     | meaning
  // IDLE      | line low, waiting for a commit
  // HIGH      | line high for T0H/T1H of the current bit
  // LOW       | line low for the rest of the bit period
  // GAP       | latch gap after the last bit; a queued commit restarts here

  localparam int NBYTES = LED_CNT * CHANNELS;
  localparam int NBITS  = NBYTES * 8;
  localparam int BW     = $clog2(NBITS);
  localparam int CMAX   = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int CW     = $clog2(CMAX);

  localparam logic [CW-1:0] LD_H0    = CW'(T0H - 1);
  localparam logic [CW-1:0] LD_H1    = CW'(T1H - 1);
  localparam logic [CW-1:0] LD_L0    = CW'(TBIT - T0H - 1);
  localparam logic [CW-1:0] LD_L1    = CW'(TBIT - T1H - 1);
  localparam logic [CW-1:0] LD_GAP   = CW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);
  localparam logic [7:0]    LAST_PTR = 8'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t        state;
  logic [7:0]    shadow     [NBYTES];
  logic [7:0]    shadow_nxt [NBYTES];
  logic [7:0]    active     [NBYTES];
  logic [7:0]    ptr;
  logic          ptr_phase;
  logic          dirty;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [BW-1:0] nxt_idx;
  logic          cur_bit;
  logic          nxt_bit;
  logic          first_bit;
  logic          wr_en;
  logic          commit_req;
  logic          gap_done;
  logic          load;

  assign wr_en      = rx_valid && !ptr_phase && ({1'b0, ptr} < 9'(NBYTES));
  assign commit_req = rx_stop && (dirty || wr_en);
  assign gap_done   = (state == GAP) && (cnt == '0);
  assign load       = ((state == IDLE) && commit_req) || (gap_done && (pending_o || commit_req));

  // A byte arriving with STOP must already be part of the frame being committed.
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      shadow_nxt[i] = (wr_en && (ptr == 8'(i))) ? rx_data : shadow[i];
    end
  end

  assign nxt_idx   = bit_idx + BW'(1);
  assign cur_bit   = active[bit_idx[BW-1:3]][~bit_idx[2:0]];
  assign nxt_bit   = active[nxt_idx[BW-1:3]][~nxt_idx[2:0]];
  assign first_bit = shadow_nxt[0][7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      ptr_phase <= 1'b1;
      dirty     <= 1'b0;
      for (int i = 0; i < NBYTES; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NBYTES; i++) shadow[i] <= shadow_nxt[i];
      if (rx_valid && ptr_phase) begin
        ptr       <= rx_data;
        ptr_phase <= 1'b0;
      end else if (wr_en) begin
        ptr <= (ptr == LAST_PTR) ? 8'd0 : ptr + 8'd1;
      end
      if (rx_start) ptr_phase <= 1'b1;
      if (load) dirty <= 1'b0;
      else if (wr_en) dirty <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      led_o     <= 1'b0;
      busy_o    <= 1'b0;
      pending_o <= 1'b0;
      for (int i = 0; i < NBYTES; i++) active[i] <= '0;
    end else begin
      led_o <= (state == HIGH);
      if (load) begin
        for (int i = 0; i < NBYTES; i++) active[i] <= shadow_nxt[i];
        state     <= HIGH;
        busy_o    <= 1'b1;
        pending_o <= 1'b0;
        bit_idx   <= '0;
        cnt       <= first_bit ? LD_H1 : LD_H0;
      end else begin
        if (commit_req && (state != IDLE)) pending_o <= 1'b1;
        case (state)
          HIGH: begin
            if (cnt == '0) begin
              state <= LOW;
              cnt   <= cur_bit ? LD_L1 : LD_L0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          LOW: begin
            if (cnt == '0) begin
              if (bit_idx == LAST_BIT) begin
                state <= GAP;
                cnt   <= LD_GAP;
              end else begin
                bit_idx <= nxt_idx;
                state   <= HIGH;
                cnt     <= nxt_bit ? LD_H1 : LD_H0;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
